mc_datapath_md: RTL

Parametrised multicycle MIPS datapath that adds an iterative multiply/divide unit with HI/LO registers to the existing multicycle datapath. It sits between the multicycle controller and the unified instruction/data memory. The controller sequences it exactly as before, plus an `md_start`/`md_done` handshake for MULT/MULTU/DIV/DIVU and a write-back source for MFHI/MFLO. All multicycle state registers live here: PC, IR, MDR, A, B, ALUOut, HI, LO, and the multiply/divide iteration state.

---
 rtl/mc_datapath_md.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_datapath_md.sv
// Multicycle MIPS datapath with an iterative multiply/divide unit and HI/LO.
// Holds PC, IR, MDR, A, B, ALUOut, HI, LO and the radix-2 iteration state.
module mc_datapath_md #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             iord,
  input  logic             regdst,
  input  logic [1:0]       memtoreg,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic [2:0]       alucontrol,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] readdata
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   pc_q, pc_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   aluout_q, aluout_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        ir_q, ir_d;
  logic               md_busy_q, md_busy_d, md_done_q, md_done_d;
  logic               md_div_q, md_div_d, md_negq_q, md_negq_d, md_negr_q, md_negr_d;
  logic [CW-1:0]      md_cnt_q, md_cnt_d;
  logic [2*WIDTH-1:0] md_prod_q, md_prod_d;
  logic [WIDTH-1:0]   md_mcand_q, md_mcand_d;
  logic [WIDTH-1:0]   rf_q [32];

  logic [4:0]         wa_s;
  logic [WIDTH-1:0]   rd1_s, rd2_s, wd_s, signimm_s, srca_s, srcb_s, aluresult_s, pcnext_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic               sa_s, sb_s;
  logic [WIDTH:0]     mul_sum_s, div_rem_s, div_diff_s;

  assign op        = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign adr       = iord ? aluout_q : pc_q;
  assign writedata = b_q;
  assign md_busy   = md_busy_q;
  assign md_done   = md_done_q;
  assign zero      = (aluresult_s == {WIDTH{1'b0}});

  assign wa_s      = regdst ? ir_q[15:11] : ir_q[20:16];
  assign rd1_s     = (ir_q[25:21] == 5'd0) ? {WIDTH{1'b0}} : rf_q[ir_q[25:21]];
  assign rd2_s     = (ir_q[20:16] == 5'd0) ? {WIDTH{1'b0}} : rf_q[ir_q[20:16]];
  assign signimm_s = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign srca_s    = alusrca ? a_q : pc_q;

  // Register-file write-data, ALU-B and next-PC source selection
  always_comb begin
    case (memtoreg)
      2'b00:   wd_s = aluout_q;
      2'b01:   wd_s = mdr_q;
      2'b10:   wd_s = lo_q;
      2'b11:   wd_s = hi_q;
      default: wd_s = aluout_q;
    endcase
    case (alusrcb)
      2'b00:   srcb_s = b_q;
      2'b01:   srcb_s = {{(WIDTH-3){1'b0}}, 3'd4};
      2'b10:   srcb_s = signimm_s;
      2'b11:   srcb_s = {signimm_s[WIDTH-3:0], 2'b00};
      default: srcb_s = b_q;
    endcase
    case (pcsrc)
      2'b00:   pcnext_s = aluresult_s;
      2'b01:   pcnext_s = aluout_q;
      2'b10:   pcnext_s = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
      2'b11:   pcnext_s = a_q;
      default: pcnext_s = aluresult_s;
    endcase
  end

  // ALU; unlisted operation codes produce zero
  always_comb begin
    case (alucontrol)
      3'b010:  aluresult_s = srca_s + srcb_s;
      3'b110:  aluresult_s = srca_s - srcb_s;
      3'b000:  aluresult_s = srca_s & srcb_s;
      3'b001:  aluresult_s = srca_s | srcb_s;
      3'b111:  aluresult_s = {{(WIDTH-1){1'b0}}, ($signed(srca_s) < $signed(srcb_s))};
      default: aluresult_s = {WIDTH{1'b0}};
    endcase
  end

  // Next values of the multicycle state registers
  always_comb begin
    pc_d     = pcen ? pcnext_s : pc_q;
    ir_d     = irwrite ? readdata[31:0] : ir_q;
    mdr_d    = readdata;
    a_d      = rd1_s;
    b_d      = rd2_s;
    aluout_d = aluresult_s;
  end

  // Operand magnitudes and one radix-2 step for multiply (shift-add) and divide (restoring)
  assign sa_s       = ~md_op[0] & a_q[WIDTH-1];
  assign sb_s       = ~md_op[0] & b_q[WIDTH-1];
  assign a_mag_s    = sa_s ? ({WIDTH{1'b0}} - a_q) : a_q;
  assign b_mag_s    = sb_s ? ({WIDTH{1'b0}} - b_q) : b_q;
  assign mul_sum_s  = {1'b0, md_prod_q[2*WIDTH-1:WIDTH]} +
                      (md_prod_q[0] ? {1'b0, md_mcand_q} : {(WIDTH+1){1'b0}});
  assign div_rem_s  = {md_prod_q[2*WIDTH-1:WIDTH], md_prod_q[WIDTH-1]};
  assign div_diff_s = div_rem_s - {1'b0, md_mcand_q};

  // Multiply/divide sequencing: accept, WIDTH iteration steps, then sign-correct into HI/LO
  always_comb begin
    md_busy_d  = md_busy_q;
    md_done_d  = 1'b0;
    md_cnt_d   = md_cnt_q;
    md_div_d   = md_div_q;
    md_negq_d  = md_negq_q;
    md_negr_d  = md_negr_q;
    md_prod_d  = md_prod_q;
    md_mcand_d = md_mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (md_busy_q) begin
      if (md_cnt_q == CW'(WIDTH)) begin
        md_busy_d = 1'b0;
        md_done_d = 1'b1;
        if (md_div_q) begin
          // A zero divisor leaves the dividend as remainder; quotient is forced to all ones
          lo_d = (md_mcand_q == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} :
                 (md_negq_q ? ({WIDTH{1'b0}} - md_prod_q[WIDTH-1:0]) : md_prod_q[WIDTH-1:0]);
          hi_d = md_negr_q ? ({WIDTH{1'b0}} - md_prod_q[2*WIDTH-1:WIDTH])
                           : md_prod_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = md_negq_q ? ({(2*WIDTH){1'b0}} - md_prod_q) : md_prod_q;
        end
      end else begin
        md_cnt_d = md_cnt_q + CW'(1);
        if (md_div_q) begin
          if (div_diff_s[WIDTH]) begin
            md_prod_d = {div_rem_s[WIDTH-1:0], md_prod_q[WIDTH-2:0], 1'b0};
          end else begin
            md_prod_d = {div_diff_s[WIDTH-1:0], md_prod_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          md_prod_d = {mul_sum_s, md_prod_q[WIDTH-1:1]};
        end
      end
    end else if (md_start) begin
      md_busy_d  = 1'b1;
      md_cnt_d   = {CW{1'b0}};
      md_div_d   = md_op[1];
      md_negq_d  = sa_s ^ sb_s;
      md_negr_d  = sa_s;
      md_prod_d  = {{WIDTH{1'b0}}, (md_op[1] ? a_mag_s : b_mag_s)};
      md_mcand_d = md_op[1] ? b_mag_s : a_mag_s;
    end else begin
      md_busy_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      mdr_q      <= {WIDTH{1'b0}};
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      aluout_q   <= {WIDTH{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      md_busy_q  <= 1'b0;
      md_done_q  <= 1'b0;
      md_cnt_q   <= {CW{1'b0}};
      md_div_q   <= 1'b0;
      md_negq_q  <= 1'b0;
      md_negr_q  <= 1'b0;
      md_prod_q  <= {(2*WIDTH){1'b0}};
      md_mcand_q <= {WIDTH{1'b0}};
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      aluout_q   <= aluout_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      md_busy_q  <= md_busy_d;
      md_done_q  <= md_done_d;
      md_cnt_q   <= md_cnt_d;
      md_div_q   <= md_div_d;
      md_negq_q  <= md_negq_d;
      md_negr_q  <= md_negr_d;
      md_prod_q  <= md_prod_d;
      md_mcand_q <= md_mcand_d;
    end
  end

  // Register file write port; contents are deliberately not reset and r0 is never written
  always_ff @(posedge clk) begin
    if (regwrite && (wa_s != 5'd0)) begin
      rf_q[wa_s] <= wd_s;
    end
  end

endmodule
